pkt_proc_sequencer: RTL and testbench
=====================================

Name: pkt_proc_sequencer

Overview:
- Sequences one packet at a time through the fifo_sram + datapath pair.
- Accepts a complete packet into the FIFO, then holds further input.
- Restarts the processor and runs it until it signals done, then drains the processed packet to the output.
- Flushes the packet instead on processor timeout or oversize packet, and keeps packet and drop statistics.

Parameters:
CTRL_WIDTH, 8, width of the packet ctrl bus
WCNT_WIDTH, 10, width of the packet word counter; matches the FIFO IAWIDTH
MAX_WORDS, 1000, largest accepted packet in words; must be below the FIFO depth
TIMEOUT_CYCLES, 4096, processor cycle budget per packet
STAT_WIDTH, 32, width of the statistics counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_wr  in  1  upstream write strobe, qualified by in_rdy
in_ctrl  in  CTRL_WIDTH  ctrl word of the current input beat
fifo_almfull  in  1  almfull from fifo_sram
fifo_stall  in  1  stall from fifo_sram
fifo_empty  in  1  fifo_empty from fifo_sram
out_almfull  in  1  downstream almost-full
cpu_done  in  1  processor done flag, level, from the datapath
in_rdy  out  1  upstream may write this cycle
fifo_wea  out  1  FIFO write enable (in_wr & in_rdy)
fifo_reb  out  1  FIFO read enable
out_wr  out  1  output write strobe (fifo_reb delayed 1 cycle, SEND only)
pc_en  out  1  processor run enable
cpu_rst  out  1  one-cycle processor PC reset
busy  out  1  state != IDLE
pkt_count  out  STAT_WIDTH  packets forwarded
drop_count  out  STAT_WIDTH  packets dropped
state_dbg  out  3  encoded current state

Behaviour:
Reset:
- State goes to IDLE.
- All outputs are 0 except in_rdy, which is 1 if the FIFO is not almfull/stall.
- Counters are cleared.
- Reset mid-operation abandons the packet. No flush is performed; the FIFO is reset by the same reset.

States: IDLE=0, RECV=1, START=2, PROC=3, SEND=4, FLUSH=5.

Input side:
- in_rdy = (state==IDLE or RECV) & !fifo_almfull & !fifo_stall (combinational).
- An accepted beat is in_wr & in_rdy.
- word_cnt increments on each accepted beat and is cleared on IDLE entry.
- seen_data is set on an accepted beat with in_ctrl==0.
- EOP is an accepted beat with in_ctrl!=0 and seen_data=1, i.e. header beats (nonzero ctrl before any data beat) are not EOP.

Transitions:
- IDLE -> RECV on the first accepted beat.
- RECV -> START on the EOP beat. pkt_len latches word_cnt+1.
- RECV -> FLUSH if an accepted beat makes word_cnt+1 == MAX_WORDS without EOP. pkt_len latches MAX_WORDS and in_rdy drops the next cycle.
- START lasts exactly 1 cycle: cpu_rst=1, pc_en=0, and the timeout counter is cleared. START -> PROC.
- In PROC, pc_en=1 and tcnt increments each cycle.
  - cpu_done=1 -> SEND, with pc_en low in the SEND cycle.
  - Otherwise tcnt==TIMEOUT_CYCLES-1 -> FLUSH.
  - cpu_done wins over timeout in the same cycle.
- In SEND, fifo_reb = !out_almfull & !fifo_empty & (rd_left!=0).
  - rd_left loads pkt_len on entry and decrements per fifo_reb.
  - out_wr = fifo_reb registered.
  - When rd_left reaches 0 (last reb issued), the next state is IDLE.
  - pkt_count increments on the SEND->IDLE transition.
- In FLUSH, fifo_reb is identical to SEND but out_wr stays 0.
  - Exit to IDLE as for SEND.
  - drop_count increments on exit.
  - The out_almfull gate also applies in FLUSH, to keep a single reb equation.
- IDLE entry clears word_cnt, seen_data and tcnt.

Timing:
- Beat-to-beat throughput is 1 per cycle on both the input and output sides.
- Latency from EOP accept to pc_en=1 is 2 cycles.
- Latency from cpu_done sample to the first fifo_reb is 1 cycle when the output is ready.

Counters:
- Statistics counters wrap modulo 2^STAT_WIDTH.
- The word counter never exceeds MAX_WORDS.

Boundary behaviour:
- cpu_done asserted outside PROC is ignored.
- A 1-beat packet cannot form EOP (it lacks a data beat); it remains in RECV until a qualifying EOP arrives.
- fifo_empty while rd_left>0 holds reb low with no state change.
- out_almfull holds reb low; already-issued reads still produce out_wr the next cycle.

Test Plan:
1. Reset, then a 2 header (ctrl FF) + 6 data + 1 EOP (ctrl 01) packet, with cpu_done raised 20 cycles after pc_en -> cpu_rst pulses 1 cycle at START; pc_en is high 20 cycles; exactly 9 reb and 9 out_wr; pkt_count=1; in_rdy=0 from EOP+1 until IDLE.
2. Same packet with cpu_done never raised and TIMEOUT_CYCLES=64 -> pc_en high exactly 64 cycles; then FLUSH with 9 reb, 0 out_wr; drop_count=1, pkt_count=0.
3. cpu_done rises in the same cycle that tcnt hits TIMEOUT_CYCLES-1 -> SEND taken; pkt_count=1, drop_count=0.
4. out_almfull toggled 3 on / 2 off during SEND of a 9-word packet -> no reb while almfull; total out_wr=9; IDLE reached only after the 9th reb.
5. MAX_WORDS=16 and 20 data beats with no EOP -> in_rdy falls after the 16th accepted beat; FLUSH 16 reads; drop_count=1.
6. Reset asserted mid-PROC and mid-SEND -> next cycle state_dbg=0, pc_en=0, fifo_reb=0, counters=0; a following normal packet completes correctly.

Source files
------------

// File: rtl/pkt_proc_sequencer.sv
// Packet sequencer: one packet at a time through FIFO and processor.
// Receive, restart the processor, then forward or flush the packet.
module pkt_proc_sequencer #(
  parameter int CTRL_WIDTH     = 8,
  parameter int WCNT_WIDTH     = 10,
  parameter int MAX_WORDS      = 1000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int STAT_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_wr,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  fifo_almfull,
  input  logic                  fifo_stall,
  input  logic                  fifo_empty,
  input  logic                  out_almfull,
  input  logic                  cpu_done,
  output logic                  in_rdy,
  output logic                  fifo_wea,
  output logic                  fifo_reb,
  output logic                  out_wr,
  output logic                  pc_en,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] pkt_count,
  output logic [STAT_WIDTH-1:0] drop_count,
  output logic [2:0]            state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCNT_WIDTH-1:0] W_ONE = WCNT_WIDTH'(1);
  localparam logic [WCNT_WIDTH-1:0] W_MAX = WCNT_WIDTH'(MAX_WORDS);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_START = 3'd2,
    S_PROC  = 3'd3,
    S_SEND  = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

  state_t state, state_n;

  logic [WCNT_WIDTH-1:0] word_cnt;
  logic [WCNT_WIDTH-1:0] pkt_len;
  logic [WCNT_WIDTH-1:0] rd_left;
  logic [TW-1:0]         tcnt;
  logic                  seen_data;
  logic                  accept;
  logic                  eop;
  logic                  full_hit;
  logic                  last_rd;
  logic                  draining;

  assign in_rdy = (state == S_IDLE || state == S_RECV)
                  && !fifo_almfull && !fifo_stall;
  assign accept   = in_wr && in_rdy;
  assign fifo_wea = accept;

  // Header beats carry nonzero ctrl before any data, so they are not EOP
  assign eop      = accept && (in_ctrl != '0) && seen_data;
  assign full_hit = accept && (word_cnt + W_ONE == W_MAX);

  assign draining = (state == S_SEND) || (state == S_FLUSH);
  assign fifo_reb = draining && !out_almfull
                    && !fifo_empty && (rd_left != '0);
  assign last_rd  = fifo_reb && (rd_left == W_ONE);

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    pc_en   = 1'b0;
    cpu_rst = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_n = S_RECV;
      end
      S_RECV: begin
        if (eop)           state_n = S_START;
        else if (full_hit) state_n = S_FLUSH;
      end
      S_START: begin
        cpu_rst = 1'b1;
        state_n = S_PROC;
      end
      S_PROC: begin
        pc_en = 1'b1;
        if (cpu_done)            state_n = S_SEND;
        else if (tcnt == T_LAST) state_n = S_FLUSH;
      end
      S_SEND, S_FLUSH: begin
        if (last_rd) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      word_cnt   <= '0;
      seen_data  <= 1'b0;
      tcnt       <= '0;
      pkt_len    <= '0;
      rd_left    <= '0;
      out_wr     <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      state  <= state_n;
      out_wr <= fifo_reb && (state == S_SEND);

      if (state_n == S_IDLE) begin
        word_cnt  <= '0;
        seen_data <= 1'b0;
      end else if (accept) begin
        word_cnt <= word_cnt + W_ONE;
        if (in_ctrl == '0) seen_data <= 1'b1;
      end

      if (state_n == S_IDLE || state == S_START)
        tcnt <= '0;
      else if (state == S_PROC)
        tcnt <= tcnt + TW'(1);

      if (state == S_RECV && eop)
        pkt_len <= word_cnt + W_ONE;
      else if (state == S_RECV && full_hit)
        pkt_len <= W_MAX;

      // Oversize flush bypasses pkt_len, which is latched the same cycle
      if (state == S_PROC && state_n != S_PROC)
        rd_left <= pkt_len;
      else if (state == S_RECV && state_n == S_FLUSH)
        rd_left <= W_MAX;
      else if (fifo_reb)
        rd_left <= rd_left - W_ONE;

      if (last_rd && state == S_SEND)
        pkt_count <= pkt_count + STAT_WIDTH'(1);
      if (last_rd && state == S_FLUSH)
        drop_count <= drop_count + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pkt_proc_sequencer.sv
// Directed bench for pkt_proc_sequencer.
// Small parameters make timeout and oversize paths short.
module tb_pkt_proc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_wr;
  logic [7:0]  in_ctrl;
  logic        fifo_almfull;
  logic        fifo_stall;
  logic        fifo_empty;
  logic        out_almfull;
  logic        cpu_done;
  logic        in_rdy;
  logic        fifo_wea;
  logic        fifo_reb;
  logic        out_wr;
  logic        pc_en;
  logic        cpu_rst;
  logic        busy;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;
  logic [2:0]  state_dbg;

  int n_chk  = 0;
  int n_fail = 0;

  logic mon_clr = 1'b0;
  int n_pc, n_rst, n_reb, n_owr, n_wea;
  int bad_alm, bad_rdy;

  always #5 clk = ~clk;

  pkt_proc_sequencer #(
    .CTRL_WIDTH(8),
    .WCNT_WIDTH(10),
    .MAX_WORDS(16),
    .TIMEOUT_CYCLES(64),
    .STAT_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_wr(in_wr),
    .in_ctrl(in_ctrl),
    .fifo_almfull(fifo_almfull),
    .fifo_stall(fifo_stall),
    .fifo_empty(fifo_empty),
    .out_almfull(out_almfull),
    .cpu_done(cpu_done),
    .in_rdy(in_rdy),
    .fifo_wea(fifo_wea),
    .fifo_reb(fifo_reb),
    .out_wr(out_wr),
    .pc_en(pc_en),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .pkt_count(pkt_count),
    .drop_count(drop_count),
    .state_dbg(state_dbg)
  );

  always @(negedge clk) begin
    if (mon_clr) begin
      n_pc <= 0; n_rst <= 0; n_reb <= 0;
      n_owr <= 0; n_wea <= 0;
      bad_alm <= 0; bad_rdy <= 0;
    end else begin
      if (pc_en)    n_pc  <= n_pc + 1;
      if (cpu_rst)  n_rst <= n_rst + 1;
      if (fifo_reb) n_reb <= n_reb + 1;
      if (out_wr)   n_owr <= n_owr + 1;
      if (fifo_wea) n_wea <= n_wea + 1;
      if (fifo_reb && out_almfull) bad_alm <= bad_alm + 1;
      if (in_rdy && state_dbg >= 3'd2) bad_rdy <= bad_rdy + 1;
    end
  end

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic beat(input logic [7:0] c);
    in_wr = 1'b1;
    in_ctrl = c;
    @(posedge clk); #1;
    in_wr = 1'b0;
    in_ctrl = 8'h00;
  endtask

  task automatic send_pkt();
    beat(8'hFF);
    beat(8'hFF);
    for (int i = 0; i < 6; i++) beat(8'h00);
    beat(8'h01);
  endtask

  task automatic wait_state(input string tag, input int s,
                            input int bound);
    int k = 0;
    while (32'(state_dbg) != s && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, 32'(state_dbg), s);
  endtask

  task automatic run_pkt(input string tag);
    send_pkt();
    @(posedge clk); #1;
    cpu_done = 1'b1;
    @(posedge clk); #1;
    cpu_done = 1'b0;
    wait_state(tag, 0, 40);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int kk;
    int first_block;
    reset = 1'b1; in_wr = 1'b0; in_ctrl = 8'h00;
    fifo_almfull = 1'b0; fifo_stall = 1'b0;
    fifo_empty = 1'b0; out_almfull = 1'b0;
    cpu_done = 1'b0;

    // reset state
    do_reset();
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_cpu_rst", 32'(cpu_rst), 0);
    chk("rst_reb", 32'(fifo_reb), 0);
    chk("rst_out_wr", 32'(out_wr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pkt", 32'(pkt_count), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_in_rdy", 32'(in_rdy), 1);
    fifo_almfull = 1'b1;
    in_wr = 1'b1;
    #1;
    chk("almfull_rdy", 32'(in_rdy), 0);
    chk("almfull_wea", 32'(fifo_wea), 0);
    fifo_almfull = 1'b0;
    fifo_stall = 1'b1;
    #1;
    chk("stall_rdy", 32'(in_rdy), 0);
    fifo_stall = 1'b0;
    in_wr = 1'b0;

    // 1: normal packet, done after 20 processor cycles
    send_pkt();
    chk("t1_start", 32'(state_dbg), 2);
    chk("t1_cpu_rst", 32'(cpu_rst), 1);
    chk("t1_start_pc", 32'(pc_en), 0);
    chk("t1_eop_rdy", 32'(in_rdy), 0);
    @(posedge clk); #1;
    chk("t1_pc_en", 32'(pc_en), 1);
    repeat (19) @(posedge clk);
    #1;
    cpu_done = 1'b1;
    @(posedge clk); #1;
    cpu_done = 1'b0;
    chk("t1_send", 32'(state_dbg), 4);
    chk("t1_send_pc", 32'(pc_en), 0);
    chk("t1_first_reb", 32'(fifo_reb), 1);
    wait_state("t1_idle", 0, 40);
    @(posedge clk); #1;
    chk("t1_n_pc", n_pc, 20);
    chk("t1_n_rst", n_rst, 1);
    chk("t1_n_reb", n_reb, 9);
    chk("t1_n_owr", n_owr, 9);
    chk("t1_n_wea", n_wea, 9);
    chk("t1_pkt", 32'(pkt_count), 1);
    chk("t1_drop", 32'(drop_count), 0);
    chk("t1_rdy_busy", bad_rdy, 0);

    // 2: processor timeout
    do_reset();
    send_pkt();
    wait_state("t2_flush", 5, 80);
    chk("t2_n_pc", n_pc, 64);
    chk("t2_rdy", 32'(in_rdy), 0);
    wait_state("t2_idle", 0, 40);
    @(posedge clk); #1;
    chk("t2_n_reb", n_reb, 9);
    chk("t2_n_owr", n_owr, 0);
    chk("t2_drop", 32'(drop_count), 1);
    chk("t2_pkt", 32'(pkt_count), 0);

    // 3: done on the last budget cycle, plus empty stall
    do_reset();
    send_pkt();
    @(posedge clk); #1;
    repeat (63) @(posedge clk);
    #1;
    cpu_done = 1'b1;
    @(posedge clk); #1;
    cpu_done = 1'b0;
    chk("t3_send", 32'(state_dbg), 4);
    fifo_empty = 1'b1;
    #1;
    chk("t3_empty_reb", 32'(fifo_reb), 0);
    @(posedge clk); #1;
    chk("t3_empty_hold", 32'(state_dbg), 4);
    chk("t3_empty_reb2", 32'(fifo_reb), 0);
    fifo_empty = 1'b0;
    wait_state("t3_idle", 0, 40);
    @(posedge clk); #1;
    chk("t3_n_pc", n_pc, 64);
    chk("t3_n_reb", n_reb, 9);
    chk("t3_n_owr", n_owr, 9);
    chk("t3_pkt", 32'(pkt_count), 1);
    chk("t3_drop", 32'(drop_count), 0);

    // 4: out_almfull 3 on / 2 off during SEND
    do_reset();
    send_pkt();
    @(posedge clk); #1;
    cpu_done = 1'b1;
    @(posedge clk); #1;
    cpu_done = 1'b0;
    kk = 0;
    while (kk < 100 && state_dbg != 3'd0) begin
      out_almfull = (kk % 5) < 3;
      @(posedge clk); #1;
      kk++;
    end
    out_almfull = 1'b0;
    chk("t4_idle", 32'(state_dbg), 0);
    chk("t4_cycles", kk, 24);
    chk("t4_n_reb", n_reb, 9);
    @(posedge clk); #1;
    chk("t4_n_owr", n_owr, 9);
    chk("t4_alm_reb", bad_alm, 0);
    chk("t4_pkt", 32'(pkt_count), 1);

    // 5: oversize packet, no EOP
    do_reset();
    first_block = -1;
    for (int i = 0; i < 20; i++) begin
      in_wr = 1'b1;
      in_ctrl = 8'h00;
      if (!in_rdy && first_block < 0) first_block = i;
      @(posedge clk); #1;
    end
    in_wr = 1'b0;
    chk("t5_block_at", first_block, 16);
    chk("t5_n_wea", n_wea, 16);
    wait_state("t5_idle", 0, 40);
    @(posedge clk); #1;
    chk("t5_n_reb", n_reb, 16);
    chk("t5_n_owr", n_owr, 0);
    chk("t5_drop", 32'(drop_count), 1);
    chk("t5_pkt", 32'(pkt_count), 0);

    // 7: header-only beats and stray cpu_done
    do_reset();
    cpu_done = 1'b1;
    @(posedge clk); #1;
    chk("t7_done_idle", 32'(state_dbg), 0);
    beat(8'h01);
    chk("t7_hdr_recv", 32'(state_dbg), 1);
    beat(8'h01);
    chk("t7_hdr_no_eop", 32'(state_dbg), 1);
    beat(8'h00);
    cpu_done = 1'b0;
    beat(8'h01);
    chk("t7_eop", 32'(state_dbg), 2);
    @(posedge clk); #1;
    cpu_done = 1'b1;
    @(posedge clk); #1;
    cpu_done = 1'b0;
    wait_state("t7_idle", 0, 40);
    @(posedge clk); #1;
    chk("t7_n_reb", n_reb, 4);
    chk("t7_n_owr", n_owr, 4);

    // 6: reset mid-PROC and mid-SEND
    do_reset();
    run_pkt("t6_first");
    chk("t6_pkt_pre", 32'(pkt_count), 1);
    send_pkt();
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6p_state", 32'(state_dbg), 0);
    chk("t6p_pc_en", 32'(pc_en), 0);
    chk("t6p_reb", 32'(fifo_reb), 0);
    chk("t6p_pkt", 32'(pkt_count), 0);
    chk("t6p_drop", 32'(drop_count), 0);
    run_pkt("t6_second");
    send_pkt();
    @(posedge clk); #1;
    cpu_done = 1'b1;
    @(posedge clk); #1;
    cpu_done = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6s_state", 32'(state_dbg), 0);
    chk("t6s_reb", 32'(fifo_reb), 0);
    chk("t6s_out_wr", 32'(out_wr), 0);
    chk("t6s_busy", 32'(busy), 0);
    chk("t6s_pkt", 32'(pkt_count), 0);
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    run_pkt("t6_after");
    @(posedge clk); #1;
    chk("t6_after_pkt", 32'(pkt_count), 1);
    chk("t6_after_reb", n_reb, 9);
    chk("t6_after_owr", n_owr, 9);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
